// File: rtl/converge_pkg.sv
// Shared types and fixed-point constants for the iterative-matrix convergence monitor.
package converge_pkg;

    typedef enum logic [1:0] {
        FILL,
        CMP,
        REPORT
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int FRAC_W     = 10;
    localparam int ONE        = 1 << FRAC_W;

endpackage

// File: rtl/converge_absdiff.sv
// |a - b| for signed DATA_W operands, widened to DATA_W+1 unsigned so extremes cannot wrap.
// Purely combinational, no handshake.
module converge_absdiff
    import converge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W:0]   d
);

    logic [DATA_W:0] diff;

    always_comb begin
        diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        d    = diff[DATA_W] ? (~diff + 1'b1) : diff;
    end

endmodule

// File: rtl/converge_monitor.sv
// Tracks max |cur-prev| per streamed matrix and flags convergence/timeout; results appear two cycles after the last element.
// Accepts one element per cycle except during the single REPORT cycle, where in_ready drops.
module converge_monitor
    import converge_pkg::*;
#(
    parameter int N_STOCKS     = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STABLE_ITERS = 2,
    parameter int MAX_ITERS    = 255
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [DATA_W-1:0]                 tol,
    input  logic                              in_valid,
    input  logic signed [DATA_W-1:0]          in_data,
    output logic                              in_ready,
    output logic                              done,
    output logic                              conv,
    output logic                              timeout,
    output logic [DATA_W:0]                   max_diff,
    output logic [$clog2(MAX_ITERS+1)-1:0]    iter_count
);

    localparam int E      = N_STOCKS * N_STOCKS;
    localparam int IDX_W  = (E > 1) ? $clog2(E) : 1;
    localparam int STK_W  = $clog2(STABLE_ITERS + 1);
    localparam int ITER_W = $clog2(MAX_ITERS + 1);

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx;
    logic                      first;
    logic [DATA_W:0]           cur_max;
    logic [STK_W-1:0]          streak, streak_nxt;
    logic [ITER_W-1:0]         iter_nxt;
    logic                      conv_nxt;
    logic signed [DATA_W-1:0]  prev [E];
    logic                      accept, last;
    logic [DATA_W:0]           d;

    assign in_ready = (state != REPORT);
    // clear wins over a simultaneous element; that element is dropped
    assign accept   = in_valid && in_ready && !clear;
    assign last     = (idx == IDX_W'(E - 1));

    converge_absdiff #(.DATA_W(DATA_W)) u_absdiff (
        .a (in_data),
        .b (prev[idx]),
        .d (d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = FILL;
        end else begin
            case (state)
                FILL:    if (accept && last) state_nxt = REPORT;
                CMP:     if (accept && last) state_nxt = REPORT;
                REPORT:  state_nxt = CMP;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_comb begin
        streak_nxt = '0;
        if (!first && (cur_max <= {1'b0, tol})) begin
            streak_nxt = (streak >= STK_W'(STABLE_ITERS)) ? streak : streak + 1'b1;
        end
        iter_nxt = (iter_count == ITER_W'(MAX_ITERS)) ? iter_count : iter_count + 1'b1;
        conv_nxt = (streak_nxt >= STK_W'(STABLE_ITERS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            first      <= 1'b0;
            cur_max    <= '0;
            streak     <= '0;
            iter_count <= '0;
            conv       <= 1'b0;
            timeout    <= 1'b0;
            done       <= 1'b0;
            max_diff   <= '0;
        end else begin
            done <= 1'b0;
            if (clear) begin
                idx        <= '0;
                first      <= 1'b0;
                cur_max    <= '0;
                streak     <= '0;
                iter_count <= '0;
                conv       <= 1'b0;
                timeout    <= 1'b0;
                max_diff   <= '0;
            end else begin
                if (accept) begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (state == CMP) begin
                        cur_max <= ((idx == '0) || (d > cur_max)) ? d : cur_max;
                    end
                    if ((state == FILL) && last) begin
                        first <= 1'b1;
                    end
                end
                if (state == REPORT) begin
                    first      <= 1'b0;
                    max_diff   <= first ? '1 : cur_max;
                    streak     <= streak_nxt;
                    conv       <= conv_nxt;
                    iter_count <= iter_nxt;
                    timeout    <= (iter_nxt == ITER_W'(MAX_ITERS)) && !conv_nxt;
                    done       <= 1'b1;
                end
            end
        end
    end

    // Stored matrix needs no reset: FILL overwrites every entry before it is read
    always_ff @(posedge clk) begin
        if (accept) begin
            prev[idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_converge_monitor.sv
// Directed-plus-random bench for converge_monitor against a per-matrix reference model.
module tb_converge_monitor;
    import converge_pkg::*;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int SI = 2;
    localparam int MI = 3;
    localparam int E  = N * N;
    localparam int IW = $clog2(MI + 1);

    typedef int mat_t [E];

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic [DW-1:0]        tol = '0;
    logic                 in_valid = 1'b0;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_ready, done, conv, timeout;
    logic [DW:0]          max_diff;
    logic [IW-1:0]        iter_count;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    int prev_m [E];
    bit have_prev;
    int streak_m;
    int iters_m;

    converge_monitor #(
        .N_STOCKS(N), .DATA_W(DW), .STABLE_ITERS(SI), .MAX_ITERS(MI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .tol(tol),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .done(done), .conv(conv), .timeout(timeout),
        .max_diff(max_diff), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        streak_m  = 0;
        iters_m   = 0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"},   in_ready, 1);
        check({tag, "_done"},    done, 0);
        check({tag, "_conv"},    conv, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_maxdiff"}, max_diff, 0);
        check({tag, "_iter"},    iter_count, 0);
    endtask

    task automatic stream(input string tag, input mat_t m, input int gap_pct, input int tol_v);
        int k, guard, mx, dd, exp_max, exp_conv, exp_to;
        k = 0;
        guard = 0;
        tol = DW'(tol_v);
        while (k < E && guard < 500) begin
            @(negedge clk);
            check({tag, "_ready_stream"}, in_ready, 1);
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = DW'(m[k]);
            if (in_valid) k++;
            guard++;
        end
        check({tag, "_stream_budget"}, k, E);

        if (!have_prev) begin
            exp_max  = 'h1FFFF;
            streak_m = 0;
        end else begin
            mx = 0;
            for (int i = 0; i < E; i++) begin
                dd = m[i] - prev_m[i];
                if (dd < 0) dd = -dd;
                if (dd > mx) mx = dd;
            end
            exp_max  = mx;
            streak_m = (mx <= tol_v) ? ((streak_m + 1 > SI) ? SI : streak_m + 1) : 0;
        end
        have_prev = 1'b1;
        prev_m    = m;
        iters_m   = (iters_m + 1 > MI) ? MI : iters_m + 1;
        exp_conv  = (streak_m >= SI) ? 1 : 0;
        exp_to    = (iters_m == MI && exp_conv == 0) ? 1 : 0;

        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_ready_report"}, in_ready, 0);
        check({tag, "_done_early"},   done, 0);
        @(negedge clk);
        check({tag, "_done"},    done, 1);
        check({tag, "_ready"},   in_ready, 1);
        check({tag, "_maxdiff"}, max_diff, exp_max);
        check({tag, "_conv"},    conv, exp_conv);
        check({tag, "_timeout"}, timeout, exp_to);
        check({tag, "_iter"},    iter_count, iters_m);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd5;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_idle_zero(tag);
        model_reset();
    endtask

    initial begin
        mat_t ident, bumped, lo, hi, plus100, base, nxt;
        int t;

        ident   = '{ONE, 0, 0, ONE};
        bumped  = '{ONE, 0, 0, ONE + 16};
        lo      = '{-32768, 0, 0, 0};
        hi      = '{32767, 0, 0, 0};
        plus100 = '{ONE + 100, 100, 100, ONE + 100};

        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // identity three times back to back
        for (int i = 0; i < 3; i++) stream("ident", ident, 0, 8);

        // out-of-tolerance iteration breaks the streak
        do_clear("clear_a");
        stream("s2_id", ident, 0, 8);
        stream("s2_bump", bumped, 0, 8);
        stream("s2_id1", ident, 0, 8);
        stream("s2_id2", ident, 0, 8);

        // full-scale swing must not wrap
        do_clear("clear_b");
        stream("ext_lo", lo, 0, 8);
        stream("ext_hi", hi, 0, 8);
        stream("ext_lo2", lo, 0, 8);

        // never converging reaches the iteration limit
        do_clear("clear_c");
        stream("to_a", ident, 0, 8);
        stream("to_b", plus100, 0, 8);
        stream("to_a2", ident, 0, 8);
        do_clear("clear_d");
        stream("after_clear", ident, 0, 8);

        // same data with random valid gaps
        do_clear("clear_e");
        for (int i = 0; i < 3; i++) stream("gaps", ident, 50, 8);

        // reset in the middle of a matrix
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(plus100[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check_idle_zero("mid_reset");
        rst_n = 1'b1;
        model_reset();
        stream("post_reset", ident, 0, 8);

        // randomized drift around a base matrix, with occasional exact-match tol=0
        do_clear("clear_f");
        for (int i = 0; i < E; i++) base[i] = int'($urandom_range(4000)) - 2000;
        for (int it = 0; it < 24; it++) begin
            t = int'($urandom_range(40));
            if ($urandom_range(3) == 0) begin
                nxt = base;
                t = 0;
            end else begin
                for (int i = 0; i < E; i++) nxt[i] = base[i] + int'($urandom_range(120)) - 60;
            end
            stream("rand", nxt, 30, t);
            base = nxt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
